// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit seven-segment scan controller with frame-synchronous display updates (option SEG_LZB_EN)
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [7:0] data_hi,
  input  logic [7:0] data_lo,
  output logic [3:0] nib,
  input  logic [6:0] seg_in,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_done
);
  localparam int MX = DIV > GUARD ? DIV : GUARD;
  localparam int CW = $clog2(MX + 1);
  localparam logic [1:0] BLANK = 2'd0;
  localparam logic [1:0] LATCH = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    d;
  logic [15:0]   pend_word;
  logic [15:0]   disp_word;
  logic          pend;
  logic          take;
  logic          last;
  logic          fd_nx;
  logic          lzb;
  logic [1:0]    d_nx;
  logic [15:0]   disp_nx;
  assign upd_ready = !pend;
  assign take      = upd_valid && !pend;
  assign last      = state == DRIVE && cnt == CW'(DIV - 1);
  assign d_nx      = last ? d + 2'd1 : d;
  assign disp_nx   = (frame_done && pend) ? pend_word : disp_word;
  assign fd_nx     = d == 2'd3 && ((state == LATCH && DIV == 1) || (state == DRIVE && int'(cnt) + 2 == DIV));
`ifdef SEG_LZB_EN
  assign lzb = d == 2'd3 ? disp_word[15:12] == 4'd0 :
               d == 2'd2 ? disp_word[15:8] == 8'd0 :
               d == 2'd1 ? disp_word[15:4] == 12'd0 : 1'b0;
`else
  assign lzb = 1'b0;
`endif
  // Handshake capture, frame-boundary word swap and nibble presentation for the upcoming cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_word  <= '0;
      disp_word  <= '0;
      d          <= '0;
      nib        <= '0;
      frame_done <= 1'b0;
    end else begin
      if (take) begin
        pend_word <= {data_hi, data_lo};
        pend      <= 1'b1;
      end else if (frame_done) begin
        pend      <= 1'b0;
      end
      disp_word  <= disp_nx;
      d          <= d_nx;
      nib        <= disp_nx[{d_nx, 2'b00} +: 4];
      frame_done <= fd_nx;
    end
  end
  // Slot sequencer: guard blanking, segment latch, then anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      seg_n <= 7'h7F;
      an_n  <= 4'hF;
    end else if (state == BLANK) begin
      state <= cnt == CW'(GUARD - 1) ? LATCH : BLANK;
      cnt   <= cnt == CW'(GUARD - 1) ? '0 : cnt + CW'(1);
    end else if (state == LATCH) begin
      seg_n <= seg_in;
      an_n  <= lzb ? 4'hF : ~(4'b0001 << d);
      state <= DRIVE;
      cnt   <= '0;
    end else if (state == DRIVE) begin
      state <= last ? BLANK : DRIVE;
      cnt   <= last ? '0 : cnt + CW'(1);
      an_n  <= last ? 4'hF : an_n;
    end else begin
      state <= BLANK;
      cnt   <= '0;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed table-driven bench for seg_scan_ctrl with DIV=4, GUARD=2 (slot 7, frame 28)
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] data_hi;
  logic [7:0] data_lo;
  logic [3:0] nib;
  logic [6:0] seg_in;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_done;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  localparam logic [15:0] AN_ALL = 16'h7BDE;
`ifdef SEG_LZB_EN
  localparam logic [15:0] AN_07 = 16'hFFFE;
  localparam logic [15:0] AN_50 = 16'hFFDE;
  localparam logic [15:0] AN_0F = 16'hFBDE;
  localparam logic [15:0] AN_Z  = 16'hFFFE;
`else
  localparam logic [15:0] AN_07 = AN_ALL;
  localparam logic [15:0] AN_50 = AN_ALL;
  localparam logic [15:0] AN_0F = AN_ALL;
  localparam logic [15:0] AN_Z  = AN_ALL;
`endif
  typedef struct {
    logic [15:0] word;
    logic [15:0] an;
  } vec_t;
  vec_t tv[5];
  seg_scan_ctrl #(.DIV(4), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .data_hi(data_hi), .data_lo(data_lo), .nib(nib), .seg_in(seg_in),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  assign seg_in = dec(nib);
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask
  task automatic offer(input logic [15:0] w);
    for (int i = 0; i < 60 && !upd_ready; i++) step();
    chk("offer_ready", upd_ready, 1'b1);
    upd_valid = 1'b1;
    {data_hi, data_lo} = w;
    step();
    upd_valid = 1'b0;
    chk("pend_after_offer", upd_ready, 1'b0);
  endtask
  task automatic wait_fd();
    for (int i = 0; i < 40 && !frame_done; i++) step();
    chk("fd_seen", frame_done, 1'b1);
  endtask
  task automatic walk(input logic [15:0] w, input logic [15:0] ans, input int start);
    for (int p = start; p < 28; p++) begin
      if (p % 7 == 0) begin
        chk("blank_an", an_n, 4'hF);
        chk("blank_nib", nib, w[(p / 7) * 4 +: 4]);
      end
      if (p % 7 == 3) begin
        chk("drive_an", an_n, ans[(p / 7) * 4 +: 4]);
        chk("drive_nib", nib, w[(p / 7) * 4 +: 4]);
        chk("drive_seg", seg_n, dec(w[(p / 7) * 4 +: 4]));
      end
      if (p >= 26) chk("frame_done", frame_done, p == 27);
      if (p < 27) step();
    end
  endtask
  initial begin
    tv[0] = '{16'hA53C, AN_ALL};
    tv[1] = '{16'h0007, AN_07};
    tv[2] = '{16'h1234, AN_ALL};
    tv[3] = '{16'h0050, AN_50};
    tv[4] = '{16'h0F00, AN_0F};
    rst_n = 1'b0;
    upd_valid = 1'b0;
    data_hi = '0;
    data_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_an", an_n, 4'hF);
    chk("rst_ready", upd_ready, 1'b1);
    rst_n = 1'b1;
    cyc = 0;
    chk("c0_seg", seg_n, 7'h7F);
    chk("c0_an", an_n, 4'hF);
    chk("c0_nib", nib, 4'h0);
    chk("c0_fd", frame_done, 1'b0);
    step();
    step();
    chk("c2_seg", seg_n, 7'h7F);
    chk("c2_an", an_n, 4'hF);
    step();
    chk("c3_seg", seg_n, dec(4'h0));
    chk("c3_an", an_n, 4'hE);
    repeat (3) step();
    chk("c6_an", an_n, 4'hE);
    step();
    chk("c7_an", an_n, 4'hF);
    for (int i = 0; i < 5; i++) begin
      offer(tv[i].word);
      wait_fd();
      if (i == 0) chk("first_fd_cycle", 16'(cyc), 16'd27);
      step();
      walk(tv[i].word, tv[i].an, 0);
      step();
    end
    upd_valid = 1'b1;
    {data_hi, data_lo} = 16'h1122;
    step();
    {data_hi, data_lo} = 16'h3344;
    chk("b2b_first_taken", upd_ready, 1'b0);
    begin
      int early = 0;
      for (int i = 0; i < 40 && !frame_done; i++) begin
        if (upd_ready) early++;
        step();
      end
      chk("b2b_ready_early", 16'(early), 16'd0);
    end
    chk("b2b_fd", frame_done, 1'b1);
    chk("b2b_ready_at_fd", upd_ready, 1'b0);
    step();
    chk("b2b_ready_rise", upd_ready, 1'b1);
    step();
    chk("b2b_second_taken", upd_ready, 1'b0);
    upd_valid = 1'b0;
    walk(16'h1122, AN_ALL, 1);
    step();
    walk(16'h3344, AN_ALL, 0);
    step();
    wait_fd();
    chk("bnd_ready", upd_ready, 1'b1);
    upd_valid = 1'b1;
    {data_hi, data_lo} = 16'h5A6B;
    step();
    upd_valid = 1'b0;
    chk("bnd_captured", upd_ready, 1'b0);
    walk(16'h3344, AN_ALL, 0);
    step();
    walk(16'h5A6B, AN_ALL, 0);
    step();
    offer(16'hBEEF);
    repeat (17) step();
    chk("mid_an_d2", an_n, 4'hB);
    chk("mid_pend", upd_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", seg_n, 7'h7F);
    chk("async_an", an_n, 4'hF);
    chk("async_ready", upd_ready, 1'b1);
    chk("async_nib", nib, 4'h0);
    chk("async_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    walk(16'h0000, AN_Z, 0);
    step();
    walk(16'h0000, AN_Z, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the four-digit seven-segment display of the 8-bit RPN ALU board. It shares one external 4-bit hex segment decoder across all four digits by presenting one nibble at a time, latching the decoded pattern and driving one digit anode per slot. New 16-bit display words arrive through a valid/ready handshake and become visible only at frame boundaries, so a frame never mixes old and new values.

## Interface
- DIV, 50000: drive cycles per digit slot (≥1).
- GUARD, 16: anti-ghosting blank cycles before each slot (≥1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- upd_valid  in  1  new display word offered.
- upd_ready  out  1  controller can accept a word (= no update pending).
- data_hi  in  8  upper byte (digits 3,2).
- data_lo  in  8  lower byte (digits 1,0).
- nib  out  4  nibble presented to the shared decoder.
- seg_in  in  7  decoder output for nib, active-low, bit0 = segment a.
- seg_n  out  7  registered segment drive, active-low.
- an_n  out  4  digit enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers: pend_word[15:0], pend flag, disp_word[15:0], digit index d (0..3), state, cycle counter.
- Digit map: d0 = disp_lo[3:0], d1 = disp_lo[7:4], d2 = disp_hi[3:0], d3 = disp_hi[7:4]. Scan order is 0,1,2,3, then wrap to 0.
- Handshake: upd_ready = !pend. A transfer occurs when upd_valid & upd_ready; it captures {data_hi, data_lo} into pend_word and sets pend. upd_valid while ready is low is ignored. The source holds the word until the transfer occurs.
- FSM per slot:
  - BLANK: GUARD cycles. an_n = 4'hF. nib = nibble of d.
  - LATCH: 1 cycle. seg_n <= seg_in at the end of the cycle; the decoder has had at least GUARD cycles to settle.
  - DRIVE: DIV cycles. an_n[d] = 0.
  - At the end of DRIVE: d <= d+1 (mod 4), go to BLANK.
- Frame boundary is the last DRIVE cycle of d = 3:
  - frame_done = 1 for that cycle.
  - If pend, disp_word <= pend_word and pend clears, so upd_ready rises on the next cycle.
  - A handshake completing on the boundary cycle itself (pend was 0) lands in pend_word. It is shown from the following frame.
- seg_n holds its value through BLANK. Only an_n gates visibility.
- Reset (any time, including mid-slot) asynchronously forces:
  - seg_n = 7'h7F, an_n = 4'hF, nib = 0, frame_done = 0, upd_ready = 1.
  - pend = 0, pend_word = 0, disp_word = 0, d = 0, state = BLANK, counter = 0.
  - Any pending word is discarded.

## Timing
- Slot length = GUARD + 1 + DIV cycles. Frame = 4 × slot.
- After rst_n deasserts, cycle 0 is the first BLANK cycle. seg_n latches at cycle GUARD. an_n = 4'b1110 from cycle GUARD+1 through GUARD+DIV.
- Update latency: a word accepted in frame k is displayed from the first slot of frame k+1. If it is accepted on the boundary cycle of frame k, it is displayed from frame k+2.
- All outputs are registered except upd_ready, which is a registered flag with no combinational path from inputs.
- Counter width is clog2(max(DIV, GUARD)+1). The counter wraps only by explicit reload.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - d3 is blanked if disp_hi[7:4] == 0.
  - d2 is blanked if disp_hi == 0.
  - d1 is blanked if disp_hi == 0 and disp_lo[7:4] == 0.
  - d0 is never blanked.
  - A blanked digit keeps its full slot timing with an_n = 4'hF during DRIVE.
- SEG_LZB_EN undefined: all four digits are always driven, including zeros.

## Test plan
Bench uses DIV=4, GUARD=2 (slot 7 cycles, frame 28) and a behavioural hex decoder on nib→seg_in.
- Reset release → seg_n = 7'h7F and an_n = 4'hF for cycles 0–2; an_n = 4'b1110 for cycles 3–6; frame_done first pulses at cycle 27.
- Load 0xA5/0x3C in frame 0 → from frame 1, nib sequence is C,3,5,A; seg_n matches decoder patterns; an_n walks 1110, 1101, 1011, 0111.
- Offer 0x11/0x22 and then immediately 0x33/0x44 with valid held → first accepted, upd_ready = 0 until the cycle after the next frame_done, then 0x33/0x44 accepted; displayed words are 0x1122 and then 0x3344 in consecutive frames.
- Assert rst_n low mid-DRIVE of d = 2 with pend set → next edge-independent outputs are seg_n = 7'h7F and an_n = 4'hF, upd_ready = 1; after release, the display shows 0000 and the pending word is lost.
- Display 0x00/0x07 → with SEG_LZB_EN, only digit 0 is enabled (an_n low only in slot 0) and the frame is still 28 cycles; without it, all four digits are enabled showing 0,0,0,7.
- upd_valid coincident with frame_done while pend = 0 → word is captured, not shown in the next frame, shown in the one after.
